// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: two requesters (A = fare, B = distance) share one
// iterative shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Each requester has a one-deep hold register (newest value wins) and a
// per-requester BCD result register with a one-cycle done strobe.
// Build option: define BCD_ARB_RR_EN for round-robin tie-breaking;
// otherwise A has fixed priority on ties.
module bcd_conv_arbiter #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_a,
   input  logic [BIN_W-1:0]      bin_a,
   input  logic                  req_b,
   input  logic [BIN_W-1:0]      bin_b,
   output logic [4*DIGITS-1:0]   bcd_a,
   output logic [4*DIGITS-1:0]   bcd_b,
   output logic                  done_a,
   output logic                  done_b,
   output logic                  busy
);

   localparam int BW = 4*DIGITS;
   localparam int SW = BW + BIN_W;
   localparam int CW = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic [BIN_W-1:0]  hold_a_q, hold_a_d, hold_b_q, hold_b_d;
   logic              owner_q, owner_d;      // 0 = A, 1 = B
   logic [SW-1:0]     sreg_q, sreg_d, adj;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bcd_a_q, bcd_a_d, bcd_b_q, bcd_b_d;
   logic              done_a_q, done_a_d, done_b_q, done_b_d;
   logic              busy_q, busy_d;
   logic              grant, grant_b;
`ifdef BCD_ARB_RR_EN
   logic              last_q, last_d;        // 0 = A served last, 1 = B
`endif

   // Tie-break: on simultaneous pending requests pick B only when A was
   // served last (round-robin) or never (fixed priority).
   always_comb begin
      grant_b = 1'b0;
`ifdef BCD_ARB_RR_EN
      grant_b = pend_b_q & (~pend_a_q | ~last_q);
`else
      grant_b = pend_b_q & ~pend_a_q;
`endif
   end

   // Add 3 to every BCD digit above 4 before the shift.
   always_comb begin
      adj = sreg_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (sreg_q[BIN_W+4*k +: 4] > 4'd4)
            adj[BIN_W+4*k +: 4] = sreg_q[BIN_W+4*k +: 4] + 4'd3;
      end
   end

   // Next-state, request capture and result update.
   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      bcd_a_d  = bcd_a_q;
      bcd_b_d  = bcd_b_q;
      done_a_d = 1'b0;
      done_b_d = 1'b0;
      grant    = 1'b0;
`ifdef BCD_ARB_RR_EN
      last_d   = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (pend_a_q | pend_b_q) begin
               grant   = 1'b1;
               owner_d = grant_b;
               sreg_d  = SW'(grant_b ? hold_b_q : hold_a_q);
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d = adj << 1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(BIN_W-1)) state_d = DONE;
         end
         DONE: begin
            if (owner_q) begin
               bcd_b_d  = sreg_q[SW-1:BIN_W];
               done_b_d = 1'b1;
            end else begin
               bcd_a_d  = sreg_q[SW-1:BIN_W];
               done_a_d = 1'b1;
            end
`ifdef BCD_ARB_RR_EN
            last_d = owner_q;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A request in the grant cycle re-arms pend with the new value while
      // the grant consumes the old hold value.
      pend_a_d = req_a | (pend_a_q & ~(grant & ~grant_b));
      pend_b_d = req_b | (pend_b_q & ~(grant &  grant_b));
      hold_a_d = req_a ? bin_a : hold_a_q;
      hold_b_d = req_b ? bin_b : hold_b_q;
      busy_d   = (state_d != IDLE);
   end

   // State and output registers; reset abandons any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pend_a_q <= 1'b0;
         pend_b_q <= 1'b0;
         hold_a_q <= '0;
         hold_b_q <= '0;
         owner_q  <= 1'b0;
         sreg_q   <= '0;
         cnt_q    <= '0;
         bcd_a_q  <= '0;
         bcd_b_q  <= '0;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef BCD_ARB_RR_EN
         last_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         pend_a_q <= pend_a_d;
         pend_b_q <= pend_b_d;
         hold_a_q <= hold_a_d;
         hold_b_q <= hold_b_d;
         owner_q  <= owner_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         bcd_a_q  <= bcd_a_d;
         bcd_b_q  <= bcd_b_d;
         done_a_q <= done_a_d;
         done_b_q <= done_b_d;
         busy_q   <= busy_d;
`ifdef BCD_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   assign bcd_a  = bcd_a_q;
   assign bcd_b  = bcd_b_q;
   assign done_a = done_a_q;
   assign done_b = done_b_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: expected results are queued when
// a request is driven and checked in order at each done strobe.
module tb_bcd_conv_arbiter;

   localparam int BIN_W  = 10;
   localparam int DIGITS = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_a = 1'b0, req_b = 1'b0;
   logic [BIN_W-1:0]  bin_a = '0, bin_b = '0;
   logic [15:0]       bcd_a, bcd_b;
   logic              done_a, done_b, busy;

   typedef struct {
      bit          who;   // 0 = A, 1 = B
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0, n_err = 0;
   int   cyc = 0, t_a = 0, t_b = 0;

   bcd_conv_arbiter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .bin_a(bin_a), .req_b(req_b), .bin_b(bin_b),
      .bcd_a(bcd_a), .bcd_b(bcd_b), .done_a(done_a), .done_b(done_b),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference conversion by decimal division.
   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Done monitor: exclusivity, ordering and value against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (done_a || done_b)) begin
         chk("done_excl", {31'b0, done_a & done_b}, 32'd0);
         if (done_a) t_a = cyc;
         if (done_b) t_b = cyc;
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_who", {31'b0, done_b}, {31'b0, e.who});
            if (e.who) chk("bcd_b", {16'b0, bcd_b}, {16'b0, e.val});
            else       chk("bcd_a", {16'b0, bcd_a}, {16'b0, e.val});
         end
      end
   end

   task automatic push(input bit who, input int v);
      exp_t e;
      e.who = who;
      e.val = to_bcd(v);
      sb.push_back(e);
   endtask

   // One-cycle request pulse; exp=0 for values expected to be overwritten.
   task automatic req(input bit who, input int v, input bit exp);
      @(negedge clk);
      if (who) begin req_b = 1'b1; bin_b = BIN_W'(v); end
      else     begin req_a = 1'b1; bin_a = BIN_W'(v); end
      if (exp) push(who, v);
      @(negedge clk);
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   task automatic pair(input int va, input int vb, input bit b_first);
      @(negedge clk);
      req_a = 1'b1; bin_a = BIN_W'(va);
      req_b = 1'b1; bin_b = BIN_W'(vb);
      if (b_first) begin push(1, vb); push(0, va); end
      else         begin push(0, va); push(1, vb); end
      @(negedge clk);
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("drain", sb.size(), 32'd0);
      sb.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_bcd_a"}, {16'b0, bcd_a}, 32'd0);
      chk({tag, "_bcd_b"}, {16'b0, bcd_b}, 32'd0);
      chk({tag, "_flags"}, {29'b0, done_a, done_b, busy}, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int n, nb;
      #1 check_zero("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single uncontended request: latency, busy span, non-owner untouched.
      @(negedge clk);
      req_a = 1'b1; bin_a = 10'd999; push(0, 999);
      n = 0; nb = 0;
      do begin
         @(negedge clk);
         req_a = 1'b0;
         n++;
         if (busy) nb++;
      end while (!done_a && n < 40);
      chk("latency", n, 32'd13);
      chk("busy_cycles", nb, 32'd11);
      chk("bcd_b_idle", {16'b0, bcd_b}, 32'd0);
      drain(40);

      // Boundary values.
      req(0, 0, 1);    drain(40);
      req(1, 1023, 1); drain(40);
      req(0, 9, 1);    drain(40);
      req(0, 10, 1);   drain(40);

      // Simultaneous pair from reset state: A wins the first tie.
      pulse_reset();
      pair(512, 47, 0);
      drain(80);
      chk("pair_gap", t_b - t_a, 32'd12);

      // After an A-only conversion, RR favours B; fixed priority keeps A.
      req(0, 10, 1); drain(40);
`ifdef BCD_ARB_RR_EN
      pair(64, 888, 1);
`else
      pair(64, 888, 0);
`endif
      drain(80);

      // Overwrite while pending: only the newest B value is converted.
      req(0, 123, 1);
      req(1, 100, 0);
      req(1, 200, 1);
      drain(80);

      // Re-request during own conversion: old value first, then new one.
      req(0, 300, 1);
      repeat (3) @(negedge clk);
      req(0, 5, 1);
      drain(80);

      // Reset in the fourth SHIFT cycle: everything clears, no done pulse.
      req(0, 600, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1 check_zero("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("midrst_quiet", {31'b0, busy}, 32'd0);
      req(0, 77, 1);
      drain(40);

      // Random values, A then B, back to back.
      for (int i = 0; i < 6; i++) begin
         int v;
         v = int'($urandom_range(0, 1023));
         req(i[0], v, 1);
         drain(40);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
